// File: rtl/i2c_txn_ctrl_if.sv
// Host request/response and command-level I2C master handshake signals
// grouped for the transaction sequencer.
interface i2c_txn_ctrl_if;
  // host side
  logic       req;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic [3:0] rd_len;
  logic       busy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic [1:0] err;
  // I2C master side
  logic [2:0] m_cmd;
  logic [7:0] m_din;
  logic       m_wr_i2c;
  logic       m_ready;
  logic       m_done_tick;
  logic       m_ack;
  logic [7:0] m_dout;

  // Sequencer view
  modport master (
    input  req, rw, dev_addr, reg_addr, wdata, rd_len,
    input  m_ready, m_done_tick, m_ack, m_dout,
    output busy, rd_data, rd_valid, done, err,
    output m_cmd, m_din, m_wr_i2c
  );

  // Environment view (host + I2C master)
  modport slave (
    output req, rw, dev_addr, reg_addr, wdata, rd_len,
    output m_ready, m_done_tick, m_ack, m_dout,
    input  busy, rd_data, rd_valid, done, err,
    input  m_cmd, m_din, m_wr_i2c
  );
endinterface

// File: rtl/i2c_txn_ctrl.sv
// I2C transaction sequencer: turns one host request (register write, or
// register read of 1..16 bytes) into the command sequence for a
// command-level I2C master, with NACK abort and stall timeout.
module i2c_txn_ctrl #(
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 12
) (
  input  logic           clk,
  input  logic           reset,
  i2c_txn_ctrl_if.master bus
);

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_RESTART = 3'd1;
  localparam logic [2:0] CMD_STOP    = 3'd2;
  localparam logic [2:0] CMD_RD      = 3'd3;
  localparam logic [2:0] CMD_WR      = 3'd4;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic [2:0] {
    SP_START, SP_WR_DEV, SP_WR_REG, SP_WR_DATA,
    SP_RESTART, SP_WR_DEVR, SP_RD, SP_STOP
  } step_t;

  state_t          state;
  step_t           step;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      rd_cnt;

  logic            rw_q;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q;
  logic [7:0]      wdata_q;
  logic [3:0]      len_q;

  logic            busy_q;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  logic            done_q;
  logic [1:0]      err_q;
  logic [2:0]      cmd_q;
  logic [7:0]      din_q;
  logic            wr_i2c_q;

  logic [2:0]      issue_cmd;
  logic [7:0]      issue_din;
  step_t           step_nxt;
  logic            byte_step;
  logic            last_rd;
  logic            to_hit;

  assign last_rd = (rd_cnt == len_q);
  assign to_hit  = (to_cnt == TO_LAST);

  // Command/data for the current step and the step that follows it
  always_comb begin
    issue_cmd = CMD_STOP;
    issue_din = 8'h00;
    step_nxt  = SP_STOP;
    byte_step = 1'b0;
    case (step)
      SP_START: begin
        issue_cmd = CMD_START;
        step_nxt  = SP_WR_DEV;
      end
      SP_WR_DEV: begin
        issue_cmd = CMD_WR;
        issue_din = {dev_q, 1'b0};
        step_nxt  = SP_WR_REG;
        byte_step = 1'b1;
      end
      SP_WR_REG: begin
        issue_cmd = CMD_WR;
        issue_din = reg_q;
        step_nxt  = rw_q ? SP_RESTART : SP_WR_DATA;
        byte_step = 1'b1;
      end
      SP_WR_DATA: begin
        issue_cmd = CMD_WR;
        issue_din = wdata_q;
        step_nxt  = SP_STOP;
        byte_step = 1'b1;
      end
      SP_RESTART: begin
        issue_cmd = CMD_RESTART;
        step_nxt  = SP_WR_DEVR;
      end
      SP_WR_DEVR: begin
        issue_cmd = CMD_WR;
        issue_din = {dev_q, 1'b1};
        step_nxt  = SP_RD;
        byte_step = 1'b1;
      end
      SP_RD: begin
        // bit0 is the ACK we send: NACK only on the final byte
        issue_cmd = CMD_RD;
        issue_din = {7'h00, last_rd};
        step_nxt  = last_rd ? SP_STOP : SP_RD;
        byte_step = 1'b1;
      end
      default: begin
        issue_cmd = CMD_STOP;
        step_nxt  = SP_STOP;
      end
    endcase
  end

  // Request fields captured on acceptance; contents are irrelevant until then
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.req) begin
      rw_q    <= bus.rw;
      dev_q   <= bus.dev_addr;
      reg_q   <= bus.reg_addr;
      wdata_q <= bus.wdata;
      len_q   <= bus.rd_len;
    end
  end

  // Sequencer FSM: ISSUE/WAIT per step, NACK abort to STOP, timeout to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      step       <= SP_START;
      to_cnt     <= '0;
      rd_cnt     <= '0;
      busy_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 2'd0;
      cmd_q      <= CMD_STOP;
      din_q      <= 8'h00;
      wr_i2c_q   <= 1'b0;
    end else begin
      wr_i2c_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            state  <= ST_ISSUE;
            step   <= SP_START;
            to_cnt <= '0;
            rd_cnt <= '0;
            busy_q <= 1'b1;
            err_q  <= 2'd0;
          end
        end
        ST_ISSUE: begin
          if (bus.m_ready) begin
            cmd_q    <= issue_cmd;
            din_q    <= issue_din;
            wr_i2c_q <= 1'b1;
            state    <= ST_WAIT;
            to_cnt   <= '0;
          end else if (to_hit) begin
            err_q  <= 2'd2;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (byte_step && bus.m_done_tick) begin
            state  <= ST_ISSUE;
            to_cnt <= '0;
            if (step == SP_RD) begin
              rd_data_q  <= bus.m_dout;
              rd_valid_q <= 1'b1;
              step       <= step_nxt;
              if (!last_rd) rd_cnt <= rd_cnt + 1'b1;
            end else if (bus.m_ack) begin
              err_q <= 2'd1;
              step  <= SP_STOP;
            end else begin
              step <= step_nxt;
            end
          end else if (!byte_step && !wr_i2c_q && bus.m_ready) begin
            // ready in the strobe cycle itself is stale and ignored
            to_cnt <= '0;
            if (step == SP_STOP) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              step  <= step_nxt;
              state <= ST_ISSUE;
            end
          end else if (to_hit) begin
            err_q  <= 2'd2;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.m_cmd    = cmd_q;
  assign bus.m_din    = din_q;
  assign bus.m_wr_i2c = wr_i2c_q;

endmodule

// File: doc/i2c_txn_ctrl.md
Name: i2c_txn_ctrl

Overview:
Transaction sequencer that sits between a host (CPU register block or init ROM) and the command-level I2C master FSM.
- Converts one host request into the full master command sequence for a single-register write, or a register read of 1..16 bytes.
- Handles the master's ready/done handshake, slave NACK abort and a stall timeout.
- Drives the master's cmd/din/wr_i2c inputs; consumes its ready/done_tick/ack/dout outputs.

Parameters:
- TIMEOUT, 4096: max cycles allowed in any wait phase before abort.
- TO_W, 12: timeout counter width; must satisfy 2^TO_W >= TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  start transaction; sampled only in IDLE.
- rw  in  1  0 = write, 1 = read.
- dev_addr  in  7  slave address.
- reg_addr  in  8  slave register index.
- wdata  in  8  write data byte.
- rd_len  in  4  read byte count minus 1 (0 → 1 byte, 15 → 16 bytes).
- busy  out  1  transaction in progress.
- rd_data  out  8  received byte.
- rd_valid  out  1  one-cycle strobe; rd_data valid.
- done  out  1  one-cycle strobe at end of transaction.
- err  out  2  status, held until next accepted req: 0 ok, 1 NACK, 2 timeout.
- m_cmd  out  3  master command: START=0, RESTART=1, STOP=2, RD=3, WR=4.
- m_din  out  8  master data in; for RD, bit0 is the ACK to send (0 = ACK, 1 = NACK).
- m_wr_i2c  out  1  one-cycle command strobe.
- m_ready  in  1  master idle, can accept a command.
- m_done_tick  in  1  master byte (WR/RD) complete.
- m_ack  in  1  slave ack bit from last WR (1 = NACK).
- m_dout  in  8  byte received by last RD.

Behaviour:
- Reset values: busy=0, rd_data=0, rd_valid=0, done=0, err=0, m_cmd=STOP(2), m_din=0, m_wr_i2c=0. Internal state → IDLE; counters → 0.
- IDLE, req=1:
  - Latch rw, dev_addr, reg_addr, wdata, rd_len.
  - Clear err; busy=1 from the next cycle.
  - req while busy is ignored; inputs need not be held after acceptance.
- Step sequence:
  - Write: START → WR {dev_addr,0} → WR reg_addr → WR wdata → STOP.
  - Read: START → WR {dev_addr,0} → WR reg_addr → RESTART → WR {dev_addr,1} → RD × (rd_len+1) → STOP.
- Each step has two phases, ISSUE then WAIT.
  - ISSUE: wait for m_ready=1. In that cycle drive m_cmd/m_din and pulse m_wr_i2c for exactly 1 cycle, then go to WAIT.
  - m_cmd/m_din stay stable from the strobe until the next ISSUE.
- WAIT, WR/RD steps: complete on m_done_tick.
  - WR: sample m_ack the same cycle; m_ack=1 → NACK abort.
  - RD: rd_data=m_dout and rd_valid=1 the next cycle. m_din[0]=0 for every RD except the last, which uses 1.
- WAIT, START/RESTART/STOP steps: complete on the first cycle with m_ready=1 that is strictly after the strobe cycle.
- Step complete → next step's ISSUE on the following cycle.
- After STOP completes: done=1 for 1 cycle, busy=0 in the same cycle, return to IDLE.
- NACK abort:
  - Skip remaining steps; issue STOP; set err=1.
  - done pulses after STOP completes.
  - No rd_valid for skipped bytes.
- Timeout:
  - Counter clears on every phase entry and increments each cycle spent in ISSUE or WAIT.
  - Reaching TIMEOUT → err=2, done=1 for 1 cycle, busy=0, go to IDLE. No STOP is issued (master assumed hung).
  - Timeout during abort STOP → err=2 overrides 1.
- Simultaneous events:
  - m_done_tick together with m_ready in WAIT: done_tick wins, step completes.
  - done strobe and rd_valid never coincide; final rd_valid precedes STOP issue.
- Reset mid-transaction: immediate return to IDLE with reset values; no STOP is generated.
- Latency: req to first m_wr_i2c = 2 cycles when m_ready is already 1.

Test Plan:
- Write dev 0x50, reg 0x10, data 0xA5, slave always ACKs → m_din sequence 0xA0, 0x10, 0xA5; cmds 0,4,4,4,2; done=1, err=0.
- Read dev 0x68, reg 0x3B, rd_len=2, slave returns 0x11,0x22,0x33 → cmds 0,4,4,1,4,3,3,3,2; m_din 0xD0, 0x3B, 0xD1; RD ack bits 0,0,1; three rd_valid with 0x11,0x22,0x33; err=0.
- NACK on address byte (m_ack=1 on first WR done_tick) → next cmd STOP, no further WR/RD, done=1, err=1.
- m_ready held 0 after START strobe, TIMEOUT=16 → done after 16 wait cycles, err=2, busy=0, no STOP strobe.
- Assert reset while waiting on the 2nd RD → all outputs at reset values asynchronously; a new req then starts cleanly with START.
- req pulsed while busy and again 1 cycle after done → first ignored, second accepted with 2-cycle latency.
